// File: rtl/snake_body_engine.sv
// snake_body_engine: body/head tracking engine for a grid snake game.
// Holds the segment list (segment 0 is the head), applies direction requests
// on game ticks, handles growth, edge and self-collision, and answers a
// one-cycle-latency cell lookup for the renderer.
// Optional feature: define SNAKE_WRAP_EN to wrap the head around the playfield
// edges instead of ending the game when it would leave the grid.
module snake_body_engine #(
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int MAX_LEN   = 16,
    parameter int START_LEN = 3,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up,
    input  logic          down,
    input  logic          left,
    input  logic          right,
    input  logic          step,
    input  logic          grow,
    input  logic          restart,
    input  logic [XW-1:0] query_x,
    input  logic [YW-1:0] query_y,
    output logic          query_hit,
    output logic          query_head,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] length,
    output logic          running,
    output logic          game_over
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;
    typedef enum logic [1:0] {D_RIGHT, D_LEFT, D_UP, D_DOWN} dir_t;

    state_t        r_state;
    state_t        w_state_nxt;
    dir_t          r_dir;
    dir_t          r_pending_dir;
    logic          r_grow_pending;
    logic [LW-1:0] r_len;
    logic [XW-1:0] r_seg_x [MAX_LEN];
    logic [YW-1:0] r_seg_y [MAX_LEN];
    logic          r_query_hit;
    logic          r_query_head;

    dir_t          w_req_dir;
    logic          w_req_vld;
    logic          w_dir_accept;
    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_ny;
    logic          w_off;
    logic          w_grow_eff;
    logic [LW-1:0] w_cmp_lim;
    logic          w_collide;
    logic          w_step_ok;
    logic          w_step_bad;
    logic          w_q_hit;

    function automatic dir_t f_opposite(input dir_t d);
        dir_t o;
        case (d)
            D_RIGHT: o = D_LEFT;
            D_LEFT:  o = D_RIGHT;
            D_UP:    o = D_DOWN;
            default: o = D_UP;
        endcase
        return o;
    endfunction

    // Start-of-game body: horizontal line ending at the grid centre, facing right.
    function automatic logic [XW-1:0] f_init_x(input int i);
        return XW'(GRID_W / 2 - i);
    endfunction

    function automatic logic [YW-1:0] f_init_y();
        return YW'(GRID_H / 2);
    endfunction

    // Pick the highest-priority request and reject it if it would reverse the snake.
    always_comb begin
        w_req_vld = up | down | left | right;
        w_req_dir = D_RIGHT;
        if (up)
            w_req_dir = D_UP;
        else if (down)
            w_req_dir = D_DOWN;
        else if (left)
            w_req_dir = D_LEFT;
        w_dir_accept = w_req_vld && (w_req_dir != f_opposite(r_dir)) && (r_state != S_OVER);
    end

    // Candidate head position for the next tick, with edge handling.
    always_comb begin
        w_nx  = r_seg_x[0];
        w_ny  = r_seg_y[0];
        w_off = 1'b0;
        case (r_pending_dir)
            D_RIGHT: begin
                if (r_seg_x[0] == XW'(GRID_W - 1)) begin
`ifdef SNAKE_WRAP_EN
                    w_nx = '0;
`else
                    w_off = 1'b1;
`endif
                end else begin
                    w_nx = r_seg_x[0] + XW'(1);
                end
            end
            D_LEFT: begin
                if (r_seg_x[0] == '0) begin
`ifdef SNAKE_WRAP_EN
                    w_nx = XW'(GRID_W - 1);
`else
                    w_off = 1'b1;
`endif
                end else begin
                    w_nx = r_seg_x[0] - XW'(1);
                end
            end
            D_UP: begin
                if (r_seg_y[0] == '0) begin
`ifdef SNAKE_WRAP_EN
                    w_ny = YW'(GRID_H - 1);
`else
                    w_off = 1'b1;
`endif
                end else begin
                    w_ny = r_seg_y[0] - YW'(1);
                end
            end
            default: begin
                if (r_seg_y[0] == YW'(GRID_H - 1)) begin
`ifdef SNAKE_WRAP_EN
                    w_ny = '0;
`else
                    w_off = 1'b1;
`endif
                end else begin
                    w_ny = r_seg_y[0] + YW'(1);
                end
            end
        endcase
    end

    // Self-collision: the tail cell is free unless the snake grows on this tick.
    always_comb begin
        w_grow_eff = (r_grow_pending | grow) && (r_len < LW'(MAX_LEN));
        w_cmp_lim  = w_grow_eff ? r_len : (r_len - LW'(1));
        w_collide  = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LW'(i) < w_cmp_lim) && (r_seg_x[i] == w_nx) && (r_seg_y[i] == w_ny))
                w_collide = 1'b1;
        end
        w_step_ok  = (r_state == S_RUN) && step && !w_off && !w_collide;
        w_step_bad = (r_state == S_RUN) && step && (w_off || w_collide);
    end

    // Renderer lookup against live segments only.
    always_comb begin
        w_q_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LW'(i) < r_len) && (r_seg_x[i] == query_x) && (r_seg_y[i] == query_y))
                w_q_hit = 1'b1;
        end
    end

    // Game state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state and status flags.
    always_comb begin
        w_state_nxt = r_state;
        running     = 1'b0;
        game_over   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_dir_accept)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                running = 1'b1;
                if (w_step_bad)
                    w_state_nxt = S_OVER;
            end
            S_OVER: begin
                game_over = 1'b1;
                if (restart)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Body, direction and growth bookkeeping; restart reloads the start configuration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dir          <= D_RIGHT;
            r_pending_dir  <= D_RIGHT;
            r_grow_pending <= 1'b0;
            r_len          <= LW'(START_LEN);
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= f_init_x(i);
                r_seg_y[i] <= f_init_y();
            end
        end else if ((r_state == S_OVER) && restart) begin
            r_dir          <= D_RIGHT;
            r_pending_dir  <= D_RIGHT;
            r_grow_pending <= 1'b0;
            r_len          <= LW'(START_LEN);
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= f_init_x(i);
                r_seg_y[i] <= f_init_y();
            end
        end else begin
            if (w_dir_accept)
                r_pending_dir <= w_req_dir;
            if (w_step_ok) begin
                r_dir          <= r_pending_dir;
                r_grow_pending <= 1'b0;
                r_seg_x[0]     <= w_nx;
                r_seg_y[0]     <= w_ny;
                for (int i = 1; i < MAX_LEN; i++) begin
                    r_seg_x[i] <= r_seg_x[i-1];
                    r_seg_y[i] <= r_seg_y[i-1];
                end
                if (w_grow_eff)
                    r_len <= r_len + LW'(1);
            end else if (grow && (r_state != S_OVER)) begin
                r_grow_pending <= 1'b1;
            end
        end
    end

    // Registered lookup result, one cycle after the query is presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_query_hit  <= 1'b0;
            r_query_head <= 1'b0;
        end else begin
            r_query_hit  <= w_q_hit;
            r_query_head <= (r_seg_x[0] == query_x) && (r_seg_y[0] == query_y);
        end
    end

    assign query_hit  = r_query_hit;
    assign query_head = r_query_head;
    assign head_x     = r_seg_x[0];
    assign head_y     = r_seg_y[0];
    assign length     = r_len;

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine at default parameters (40x30 grid,
// 16 segments max, 3 at start). A vector table drives one cycle per record;
// hand-written sequences cover growth saturation, the grid edge and reset
// during a move.
module tb_snake_body_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       up, down, left, right, step, grow, restart;
    logic [5:0] query_x;
    logic [4:0] query_y;
    logic       query_hit, query_head;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic [4:0] length;
    logic       running, game_over;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        bit u, d, l, r, st, gr, rs;
        int qx, qy;
        int ex, ey, el;
        bit erun, eover, ehit, ehead;
    } vec_t;

    vec_t vecs[$];

    snake_body_engine dut (
        .clk(clk), .rst(rst),
        .up(up), .down(down), .left(left), .right(right),
        .step(step), .grow(grow), .restart(restart),
        .query_x(query_x), .query_y(query_y),
        .query_hit(query_hit), .query_head(query_head),
        .head_x(head_x), .head_y(head_y), .length(length),
        .running(running), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input bit u, d, l, r, st, gr, rs, input int qx, qy, ex, ey, el,
                       input bit erun, eover, ehit, ehead);
        vec_t v;
        v.u = u; v.d = d; v.l = l; v.r = r; v.st = st; v.gr = gr; v.rs = rs;
        v.qx = qx; v.qy = qy; v.ex = ex; v.ey = ey; v.el = el;
        v.erun = erun; v.eover = eover; v.ehit = ehit; v.ehead = ehead;
        vecs.push_back(v);
    endtask

    task automatic clr();
        up = 0; down = 0; left = 0; right = 0; step = 0; grow = 0; restart = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pos(input string name, input int idx, input int x, input int y, input int len);
        chk({name, "_x"}, idx, int'(head_x), x);
        chk({name, "_y"}, idx, int'(head_y), y);
        chk({name, "_len"}, idx, int'(length), len);
    endtask

    initial begin
        //    u d l r st gr rs  qx qy  ex ey el run ov hit hd
        add(0,0,0,1, 0,0,0, 20,15, 20,15,3, 1,0, 1,1);  // IDLE -> RUN, head cell
        add(0,0,0,1, 1,0,0, 19,15, 21,15,3, 1,0, 1,0);
        add(0,0,0,1, 1,0,0, 18,15, 22,15,3, 1,0, 0,0);  // stale cell beyond length
        add(0,0,0,1, 1,0,0,  0, 0, 23,15,3, 1,0, 0,0);
        add(0,0,0,0, 0,0,0, 21,15, 23,15,3, 1,0, 1,0);  // tail at (21,15)
        add(0,0,0,0, 0,0,0, 20,15, 23,15,3, 1,0, 0,0);  // dropped tail cell
        add(0,0,1,0, 0,0,0,  0, 0, 23,15,3, 1,0, 0,0);  // reverse request ignored
        add(0,0,1,0, 1,0,0, 23,15, 24,15,3, 1,0, 1,1);
        add(0,0,0,0, 0,1,0,  0, 0, 24,15,3, 1,0, 0,0);  // grow pends
        add(0,0,0,0, 1,0,0,  0, 0, 25,15,4, 1,0, 0,0);
        add(0,0,0,0, 1,1,0,  0, 0, 26,15,5, 1,0, 0,0);  // grow with step
        add(1,0,0,0, 1,0,0,  0, 0, 27,15,5, 1,0, 0,0);  // new dir waits a tick
        add(0,0,0,0, 1,0,0,  0, 0, 27,14,5, 1,0, 0,0);
        add(0,0,1,0, 0,0,0,  0, 0, 27,14,5, 1,0, 0,0);
        add(0,0,0,0, 1,0,0,  0, 0, 26,14,5, 1,0, 0,0);
        add(0,1,0,0, 0,0,0,  0, 0, 26,14,5, 1,0, 0,0);
        add(0,0,0,0, 1,0,0,  0, 0, 26,14,5, 0,1, 0,0);  // hits own body
        add(0,0,0,1, 1,0,0,  0, 0, 26,14,5, 0,1, 0,0);  // frozen in OVER
        add(0,0,0,0, 0,0,0, 27,15, 26,14,5, 0,1, 1,0);
        add(0,0,0,0, 0,0,1,  0, 0, 20,15,3, 0,0, 0,0);  // restart
        add(0,0,0,0, 1,0,0, 20,15, 20,15,3, 0,0, 1,1);  // step ignored in IDLE

        clr();
        query_x = 0; query_y = 0;
        rst = 0;
        #12;
        chk_pos("rst", 0, 20, 15, 3);
        chk("rst_run", 0, int'(running), 0);
        chk("rst_over", 0, int'(game_over), 0);
        chk("rst_qhit", 0, int'(query_hit), 0);
        chk("rst_qhead", 0, int'(query_head), 0);
        @(negedge clk);
        rst = 1;

        for (int i = 0; i < vecs.size(); i++) begin
            up = vecs[i].u; down = vecs[i].d; left = vecs[i].l; right = vecs[i].r;
            step = vecs[i].st; grow = vecs[i].gr; restart = vecs[i].rs;
            query_x = 6'(vecs[i].qx); query_y = 5'(vecs[i].qy);
            tick();
            chk_pos("vec", i, vecs[i].ex, vecs[i].ey, vecs[i].el);
            chk("vec_run", i, int'(running), int'(vecs[i].erun));
            chk("vec_over", i, int'(game_over), int'(vecs[i].eover));
            chk("vec_qhit", i, int'(query_hit), int'(vecs[i].ehit));
            chk("vec_qhead", i, int'(query_head), int'(vecs[i].ehead));
        end

        // Growth saturation: 14 grow/step pairs from length 3.
        clr();
        right = 1; tick(); right = 0;
        chk("sat_run", 0, int'(running), 1);
        for (int k = 0; k < 14; k++) begin
            grow = 1; tick(); grow = 0;
            step = 1; tick(); step = 0;
        end
        chk_pos("sat", 0, 34, 15, 16);
        query_x = 19; query_y = 15; tick();
        chk("sat_tail_hit", 0, int'(query_hit), 1);
        query_x = 18; query_y = 15; tick();
        chk("sat_past_tail", 0, int'(query_hit), 0);
        step = 1; tick(); step = 0;
        chk_pos("sat_nogrow", 0, 35, 15, 16);

        // Right edge.
        for (int k = 0; k < 4; k++) begin
            step = 1; tick(); step = 0;
        end
        chk_pos("edge_pre", 0, 39, 15, 16);
        step = 1; tick(); step = 0;
`ifdef SNAKE_WRAP_EN
        chk_pos("edge_wrap", 0, 0, 15, 16);
        chk("edge_run", 0, int'(running), 1);
        chk("edge_over", 0, int'(game_over), 0);
`else
        chk_pos("edge_stop", 0, 39, 15, 16);
        chk("edge_run", 0, int'(running), 0);
        chk("edge_over", 0, int'(game_over), 1);
`endif

        // Reset in the middle of a move.
        rst = 0; #3;
        @(negedge clk); rst = 1;
        right = 1; tick(); right = 0;
        step = 1; tick();
        chk_pos("mid_pre", 0, 21, 15, 3);
        #2 rst = 0;
        #1;
        chk_pos("mid_in_rst", 0, 20, 15, 3);
        chk("mid_run", 0, int'(running), 0);
        @(negedge clk);
        rst = 1; step = 0;
        tick();
        chk_pos("mid_after", 0, 20, 15, 3);
        chk("mid_run_after", 0, int'(running), 0);
        chk("mid_over_after", 0, int'(game_over), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
